// File: rtl/wide_fifo_axis_reader.sv
// Pops FWFT words from the wide FIFO and presents them as an AXI4-Stream master through a 2-entry skid buffer.
// Optional statistics outputs are enabled by defining WIDE_FIFO_AXIS_READER_STATS_EN.
module wide_fifo_axis_reader #(
  parameter int C_NUMBER_FIFOS = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [64*C_NUMBER_FIFOS-1:0]  FIFO_DO,
  input  logic [8*C_NUMBER_FIFOS-1:0]   FIFO_DOP,
  input  logic                          FIFO_EMPTY,
  output logic                          FIFO_RDEN,
  output logic [64*C_NUMBER_FIFOS-1:0]  M_AXIS_TDATA,
  output logic [8*C_NUMBER_FIFOS-1:0]   M_AXIS_TKEEP,
  output logic                          M_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  input  logic                          FLUSH,
  output logic                          KEEP_ERR
`ifdef WIDE_FIFO_AXIS_READER_STATS_EN
  ,
  output logic [31:0]                   STAT_PKTS,
  output logic [31:0]                   STAT_BEATS,
  output logic [15:0]                   STAT_DROPS
`endif
);

  localparam int DW = 64 * C_NUMBER_FIFOS;
  localparam int KW = 8 * C_NUMBER_FIFOS;

  typedef enum logic [1:0] {IDLE = 2'd0, PKT = 2'd1, DROP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            drop_pend_q, drop_pend_d;
  logic [1:0]      count_q, count_d;
  logic            rd_ptr_q, wr_ptr_q;
  logic            keep_err_q;
  logic [DW-1:0]   buf_data_q [2];
  logic [KW-1:0]   buf_keep_q [2];
  logic            buf_last_q [2];

  logic [KW-1:0]   in_keep;
  logic            in_last;
  logic            drop_start;
  logic            pop;
  logic            fwd;
  logic            xfer;
  logic            tvalid;
  logic            keep_bad;

  // Lane 0 of the keep mask is implied; the parity bit it would occupy carries tlast.
  assign in_keep = {FIFO_DOP[KW-1:1], 1'b1};
  assign in_last = FIFO_DOP[0];

  // A FLUSH seen in the same cycle as a packet's first pop still drops that packet.
  assign drop_start = (state_q == IDLE) && (drop_pend_q || FLUSH);
  assign pop  = ARESETN && !FIFO_EMPTY &&
                ((state_q == DROP) || drop_start || (count_q != 2'd2));
  assign fwd  = pop && (state_q != DROP) && !drop_start;
  assign tvalid = (count_q != 2'd0);
  assign xfer = tvalid && M_AXIS_TREADY;

  // Contiguous-from-LSB masks satisfy keep & (keep+1) == 0; mid-packet beats must be full.
  assign keep_bad = ((in_keep & (in_keep + KW'(1))) != '0) ||
                    (!in_last && (in_keep != '1));

  always_comb begin
    state_d     = state_q;
    drop_pend_d = drop_pend_q | FLUSH;
    if (pop) begin
      case (state_q)
        IDLE: begin
          if (drop_start) begin
            drop_pend_d = 1'b0;
            state_d     = in_last ? IDLE : DROP;
          end else begin
            state_d     = in_last ? IDLE : PKT;
          end
        end
        PKT:     if (in_last) state_d = IDLE;
        DROP:    if (in_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (fwd && !xfer) begin
      count_d = count_q + 2'd1;
    end else if (!fwd && xfer) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      drop_pend_q <= 1'b0;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      keep_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_pend_q <= drop_pend_d;
      count_q     <= count_d;
      if (fwd) wr_ptr_q <= ~wr_ptr_q;
      if (xfer) rd_ptr_q <= ~rd_ptr_q;
      if (fwd && keep_bad) keep_err_q <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge ACLK) begin
    if (fwd) begin
      buf_data_q[wr_ptr_q] <= FIFO_DO;
      buf_keep_q[wr_ptr_q] <= in_keep;
      buf_last_q[wr_ptr_q] <= in_last;
    end
  end

  assign FIFO_RDEN     = pop;
  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = tvalid ? buf_data_q[rd_ptr_q] : '0;
  assign M_AXIS_TKEEP  = tvalid ? buf_keep_q[rd_ptr_q] : '0;
  assign M_AXIS_TLAST  = tvalid ? buf_last_q[rd_ptr_q] : 1'b0;
  assign KEEP_ERR      = keep_err_q;

`ifdef WIDE_FIFO_AXIS_READER_STATS_EN
  logic [31:0] stat_pkts_q, stat_beats_q;
  logic [15:0] stat_drops_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      stat_pkts_q  <= '0;
      stat_beats_q <= '0;
      stat_drops_q <= '0;
    end else begin
      if (fwd) begin
        stat_beats_q <= stat_beats_q + 32'd1;
        if (in_last) stat_pkts_q <= stat_pkts_q + 32'd1;
      end
      if (pop && drop_start) stat_drops_q <= stat_drops_q + 16'd1;
    end
  end

  assign STAT_PKTS  = stat_pkts_q;
  assign STAT_BEATS = stat_beats_q;
  assign STAT_DROPS = stat_drops_q;
`endif

endmodule

// File: tb/tb_wide_fifo_axis_reader.sv
// Randomized and directed bench for wide_fifo_axis_reader against a packet-level reference model.
module tb_wide_fifo_axis_reader;

  localparam int N  = 4;
  localparam int DW = 64 * N;
  localparam int KW = 8 * N;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [DW-1:0] FIFO_DO = '0;
  logic [KW-1:0] FIFO_DOP = '0;
  logic          FIFO_EMPTY = 1'b1;
  logic          FIFO_RDEN;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [KW-1:0] M_AXIS_TKEEP;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY = 1'b0;
  logic          FLUSH = 1'b0;
  logic          KEEP_ERR;
`ifdef WIDE_FIFO_AXIS_READER_STATS_EN
  logic [31:0]   STAT_PKTS, STAT_BEATS;
  logic [15:0]   STAT_DROPS;
`endif

  wide_fifo_axis_reader #(.C_NUMBER_FIFOS(N)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .FIFO_DO(FIFO_DO), .FIFO_DOP(FIFO_DOP), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RDEN(FIFO_RDEN),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .FLUSH(FLUSH), .KEEP_ERR(KEEP_ERR)
`ifdef WIDE_FIFO_AXIS_READER_STATS_EN
    , .STAT_PKTS(STAT_PKTS), .STAT_BEATS(STAT_BEATS), .STAT_DROPS(STAT_DROPS)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  // Source FIFO contents and expected forwarded beats
  beat_t src_q[$];
  beat_t exp_q[$];

  // Packet-level model state
  bit m_in_pkt, m_drop, m_pend, m_keep_err;
  int m_drops;

  // Stimulus knobs
  int gap_pct, ready_pct, flush_pct;
  bit flush_req, verbose;

  // Per-test observation
  int cyc, n_pops, n_xfer, first_pop_cyc, first_xfer_cyc, last_xfer_cyc;
  logic s_tvalid, s_rden, s_keep_err;
  logic [DW-1:0] s_tdata;
  bit hold_v;
  beat_t hold_b;

  task automatic check(input string tag, input logic [295:0] got, input logic [295:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit keep_is_bad(input beat_t b);
    int n = 0;
    logic [63:0] mask;
    while (n < KW && b.keep[n]) n++;
    mask = (64'd1 << n) - 64'd1;
    return (b.keep != mask[KW-1:0]) || (!b.last && (b.keep != {KW{1'b1}}));
  endfunction

  task automatic add_beat(input logic [KW-1:0] keep, input bit last);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
    b.keep = keep | KW'(1);
    b.last = last;
    src_q.push_back(b);
  endtask

  task automatic add_rand_pkt(input int len, input int bad_pct);
    logic [63:0] m;
    logic [KW-1:0] k;
    for (int i = 0; i < len; i++) begin
      if (i != len - 1) begin
        add_beat({KW{1'b1}}, 1'b0);
      end else begin
        m = (64'd1 << $urandom_range(KW, 1)) - 64'd1;
        k = m[KW-1:0];
        if ($urandom_range(99) < bad_pct) k = KW'($urandom());
        add_beat(k, 1'b1);
      end
    end
  endtask

  task automatic clear_obs();
    n_pops = 0; n_xfer = 0;
    first_pop_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
  endtask

  // One clock: drive at posedge+1, sample and update the model at negedge.
  task automatic cycle();
    logic pop, xfer, fl;
    beat_t b, e;
    FIFO_EMPTY = (src_q.size() == 0) || ($urandom_range(99) < gap_pct);
    if (!FIFO_EMPTY) begin
      FIFO_DO  = src_q[0].data;
      FIFO_DOP = {src_q[0].keep[KW-1:1], src_q[0].last};
    end else begin
      FIFO_DO  = '0;
      FIFO_DOP = '0;
    end
    M_AXIS_TREADY = ($urandom_range(99) < ready_pct);
    fl = flush_req || ($urandom_range(99) < flush_pct);
    flush_req = 1'b0;
    FLUSH = fl;
    @(negedge ACLK);
    cyc++;
    pop  = FIFO_RDEN && !FIFO_EMPTY;
    xfer = M_AXIS_TVALID && M_AXIS_TREADY;
    s_tvalid = M_AXIS_TVALID; s_rden = FIFO_RDEN; s_keep_err = KEEP_ERR; s_tdata = M_AXIS_TDATA;
    if (!ARESETN) begin
      exp_q.delete();
      m_in_pkt = 0; m_drop = 0; m_pend = 0; m_keep_err = 0; m_drops = 0; hold_v = 0;
    end else begin
      check("keep_err", KEEP_ERR, m_keep_err);
      if (hold_v)
        check("hold_stable", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA},
              {1'b1, hold_b.last, hold_b.keep, hold_b.data});
      hold_v = M_AXIS_TVALID && !M_AXIS_TREADY;
      hold_b.data = M_AXIS_TDATA; hold_b.keep = M_AXIS_TKEEP; hold_b.last = M_AXIS_TLAST;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA}, {e.last, e.keep, e.data});
          if (verbose)
            $display("cyc %0d beat keep=%h last=%0b data[31:0]=%h",
                     cyc, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TDATA[31:0]);
        end
        n_xfer++;
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
      end
      if (pop) begin
        b = src_q.pop_front();
        n_pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        if (!m_in_pkt) begin
          m_drop = m_pend || fl;
          m_pend = 0;
          if (m_drop) m_drops++;
        end else begin
          m_pend = m_pend || fl;
        end
        if (!m_drop) begin
          exp_q.push_back(b);
          if (keep_is_bad(b)) m_keep_err = 1;
        end
        m_in_pkt = !b.last;
      end else begin
        m_pend = m_pend || fl;
      end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    cycle();
    ARESETN = 1'b1;
    clear_obs();
  endtask

  initial begin
    int budget;
    gap_pct = 0; ready_pct = 0; flush_pct = 0; flush_req = 0; verbose = 1;
    @(posedge ACLK); #1;
    do_reset();

    // Reset state
    run(1);
    check("rst_tvalid", s_tvalid, 0);
    check("rst_tdata", s_tdata, 0);
    check("rst_keep_err", s_keep_err, 0);
    check("rst_rden_empty", s_rden, 0);

    // T1: 3-beat packet at full rate
    $display("T1 three-beat packet");
    clear_obs();
    ready_pct = 100;
    add_beat(32'hFFFFFFFF, 1'b0);
    add_beat(32'hFFFFFFFF, 1'b0);
    add_beat(32'h0000FFFF, 1'b1);
    run(6);
    check("t1_beats", n_xfer, 3);
    check("t1_latency", first_xfer_cyc - first_pop_cyc, 1);
    check("t1_consecutive", last_xfer_cyc - first_xfer_cyc, 2);
    check("t1_drained", exp_q.size(), 0);

    // T2: backpressure holds exactly two buffered pops, then full-rate drain
    $display("T2 backpressure");
    do_reset();
    ready_pct = 0;
    add_rand_pkt(5, 0);
    add_rand_pkt(5, 0);
    run(8);
    check("t2_pops", n_pops, 2);
    check("t2_rden_low", s_rden, 0);
    clear_obs();
    ready_pct = 100;
    run(14);
    check("t2_beats", n_xfer, 10);
    check("t2_no_bubble", last_xfer_cyc - first_xfer_cyc, 9);

    // T3: FLUSH mid-packet A drops B only
    $display("T3 flush");
    do_reset();
    add_rand_pkt(4, 0);
    add_rand_pkt(3, 0);
    add_rand_pkt(2, 0);
    run(1);
    flush_req = 1;
    run(14);
    check("t3_beats", n_xfer, 6);
    check("t3_drained", exp_q.size() + src_q.size(), 0);
`ifdef WIDE_FIFO_AXIS_READER_STATS_EN
    check("t3_stat_drops", STAT_DROPS, 1);
    check("t3_stat_pkts", STAT_PKTS, 2);
`endif

    // T4: malformed keep is forwarded and latches KEEP_ERR
    $display("T4 keep error");
    clear_obs();
    add_beat(32'hFFFFFFFF, 1'b0);
    add_beat(32'h000000F5, 1'b1);
    run(4);
    check("t4_keep_err_set", s_keep_err, 1);
    check("t4_beats", n_xfer, 2);
    add_rand_pkt(2, 0);
    add_rand_pkt(1, 0);
    run(8);
    check("t4_keep_err_sticky", s_keep_err, 1);

    // T5: reset mid-packet with a full buffer
    $display("T5 reset mid-packet");
    clear_obs();
    ready_pct = 0;
    add_rand_pkt(6, 0);
    run(4);
    check("t5_pops_before", n_pops, 2);
    ARESETN = 1'b0;
    cycle();
    ARESETN = 1'b1;
    clear_obs();
    cycle();
    check("t5_tvalid_low", s_tvalid, 0);
    check("t5_keep_err_clr", s_keep_err, 0);
    ready_pct = 100;
    run(10);
    check("t5_beats", n_xfer, 4);
    check("t5_drained", exp_q.size() + src_q.size(), 0);

    // T6: random traffic
    $display("T6 random traffic");
    verbose = 0;
    do_reset();
    gap_pct = 25; ready_pct = 50; flush_pct = 2;
    for (int p = 0; p < 1000; p++) add_rand_pkt($urandom_range(4, 1), 5);
    budget = 40000;
    while ((src_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
      cycle();
      budget--;
    end
    flush_pct = 0;
    run(4);
    check("t6_drained", exp_q.size() + src_q.size(), 0);
    check("t6_tvalid_idle", s_tvalid, 0);
    $display("T6 done: %0d beats forwarded, %0d packets dropped", n_xfer, m_drops);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
